// File: rtl/simmem_release_scheduler.sv
// Slot-based delay scheduler driving one simmem bank's per-ID release enables.
// Optional SIMMEM_RELEASE_SCHEDULER_FREEZE_EN adds freeze_i to stall all countdowns.
module simmem_release_scheduler #(
  parameter int unsigned IDWidth    = 8,
  parameter int unsigned NumSlots   = 8,
  parameter int unsigned DelayWidth = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
`ifdef SIMMEM_RELEASE_SCHEDULER_FREEZE_EN
  input  logic                               freeze_i,
`endif
  input  logic                               delay_in_valid_i,
  output logic                               delay_in_ready_o,
  input  logic [IDWidth-1:0]                 delay_id_i,
  input  logic [DelayWidth-1:0]              delay_cycles_i,
  output logic [(2**IDWidth)-1:0]            release_en_o,
  input  logic                               released_valid_i,
  input  logic [IDWidth-1:0]                 released_id_i,
  output logic [$clog2(NumSlots+1)-1:0]      occupancy_o,
  output logic                               error_o
);

  localparam int unsigned OccWidth = $clog2(NumSlots + 1);

  typedef enum logic [1:0] {
    SLOT_FREE     = 2'd0,
    SLOT_COUNTING = 2'd1,
    SLOT_EXPIRED  = 2'd2
  } slot_state_e;

  slot_state_e           state_q [NumSlots];
  slot_state_e           state_d [NumSlots];
  logic [IDWidth-1:0]    id_q    [NumSlots];
  logic [IDWidth-1:0]    id_d    [NumSlots];
  logic [DelayWidth-1:0] cnt_q   [NumSlots];
  logic [DelayWidth-1:0] cnt_d   [NumSlots];
  logic [OccWidth-1:0]   occ_q, occ_d;
  logic                  error_q, error_d;

  logic [NumSlots-1:0]   alloc_oh, rel_oh;
  logic                  alloc_found, rel_found, do_alloc, stall;

`ifdef SIMMEM_RELEASE_SCHEDULER_FREEZE_EN
  assign stall = freeze_i;
`else
  assign stall = 1'b0;
`endif

  // Lowest-index free slot for allocation, lowest-index matching expired slot for release.
  always_comb begin
    alloc_oh    = '0;
    rel_oh      = '0;
    alloc_found = 1'b0;
    rel_found   = 1'b0;
    for (int s = 0; s < NumSlots; s++) begin
      if (!alloc_found && state_q[s] == SLOT_FREE) begin
        alloc_oh[s] = 1'b1;
        alloc_found = 1'b1;
      end
      if (!rel_found && released_valid_i && state_q[s] == SLOT_EXPIRED &&
          id_q[s] == released_id_i) begin
        rel_oh[s] = 1'b1;
        rel_found = 1'b1;
      end
    end
  end

  assign delay_in_ready_o = alloc_found;
  assign do_alloc         = delay_in_valid_i & alloc_found;

  // Per-slot FREE -> COUNTING -> EXPIRED -> FREE next-state logic.
  always_comb begin
    for (int s = 0; s < NumSlots; s++) begin
      state_d[s] = state_q[s];
      id_d[s]    = id_q[s];
      cnt_d[s]   = cnt_q[s];
      case (state_q[s])
        SLOT_FREE: begin
          if (do_alloc && alloc_oh[s]) begin
            state_d[s] = SLOT_COUNTING;
            id_d[s]    = delay_id_i;
            cnt_d[s]   = delay_cycles_i;
          end
        end
        SLOT_COUNTING: begin
          if (!stall) begin
            if (cnt_q[s] == '0) state_d[s] = SLOT_EXPIRED;
            else                cnt_d[s]   = cnt_q[s] - DelayWidth'(1);
          end
        end
        SLOT_EXPIRED: begin
          if (rel_oh[s]) state_d[s] = SLOT_FREE;
        end
        default: state_d[s] = SLOT_FREE;
      endcase
    end
    occ_d   = occ_q + OccWidth'(do_alloc) - OccWidth'(rel_found);
    error_d = error_q | (released_valid_i & ~rel_found);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < NumSlots; s++) begin
        state_q[s] <= SLOT_FREE;
        id_q[s]    <= '0;
        cnt_q[s]   <= '0;
      end
      occ_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      occ_q   <= occ_d;
      error_q <= error_d;
    end
  end

  // Release enables decoded straight from slot flops.
  always_comb begin
    release_en_o = '0;
    for (int s = 0; s < NumSlots; s++) begin
      if (state_q[s] == SLOT_EXPIRED) release_en_o[id_q[s]] = 1'b1;
    end
  end

  assign occupancy_o = occ_q;
  assign error_o     = error_q;

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Self-checking bench for simmem_release_scheduler: directed table, corner sequences,
// and random traffic against a timestamp-based reference model.
module tb_simmem_release_scheduler;

  localparam int unsigned NSlots = 8;
  localparam int unsigned OccW   = $clog2(NSlots + 1);

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [7:0]     in_id;
  logic [7:0]     in_delay;
  logic [255:0]   rel_en;
  logic           rvalid;
  logic [7:0]     rid;
  logic [OccW-1:0] occ;
  logic           err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  simmem_release_scheduler dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
`ifdef SIMMEM_RELEASE_SCHEDULER_FREEZE_EN
    .freeze_i         (1'b0),
`endif
    .delay_in_valid_i (in_valid),
    .delay_in_ready_o (in_ready),
    .delay_id_i       (in_id),
    .delay_cycles_i   (in_delay),
    .release_en_o     (rel_en),
    .released_valid_i (rvalid),
    .released_id_i    (rid),
    .occupancy_o      (occ),
    .error_o          (err)
  );

  // Model: each busy slot remembers the edge number after which it counts as expired.
  bit m_busy [NSlots];
  int m_id   [NSlots];
  int m_exp  [NSlots];
  bit m_err;
  int m_n;

  function automatic void model_reset();
    for (int s = 0; s < NSlots; s++) begin
      m_busy[s] = 1'b0; m_id[s] = 0; m_exp[s] = 0;
    end
    m_err = 1'b0;
    m_n   = 0;
  endfunction

  function automatic bit model_expired(input int s);
    return m_busy[s] && (m_n >= m_exp[s]);
  endfunction

  function automatic bit model_ready();
    for (int s = 0; s < NSlots; s++) if (!m_busy[s]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_occ();
    int c = 0;
    for (int s = 0; s < NSlots; s++) if (m_busy[s]) c++;
    return c;
  endfunction

  function automatic logic [255:0] model_rel();
    logic [255:0] r = '0;
    for (int s = 0; s < NSlots; s++) if (model_expired(s)) r[m_id[s]] = 1'b1;
    return r;
  endfunction

  function automatic void model_step(input bit v, input int id, input int d,
                                     input bit rv, input int r);
    int fi = -1;
    int ri = -1;
    for (int s = 0; s < NSlots; s++) begin
      if (fi < 0 && !m_busy[s]) fi = s;
      if (ri < 0 && rv && model_expired(s) && m_id[s] == r) ri = s;
    end
    if (rv && ri < 0) m_err = 1'b1;
    if (v && fi >= 0) begin
      m_busy[fi] = 1'b1; m_id[fi] = id; m_exp[fi] = m_n + 1 + d + 1;
    end
    if (ri >= 0) m_busy[ri] = 1'b0;
    m_n++;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one edge's inputs, advance model, compare every output against it.
  task automatic cycle(input logic v, input logic [7:0] id, input logic [7:0] d,
                       input logic rv, input logic [7:0] r);
    in_valid = v; in_id = id; in_delay = d; rvalid = rv; rid = r;
    @(posedge clk);
    model_step(v, int'(id), int'(d), rv, int'(r));
    #1;
    chk("model_ready", 256'(in_ready), 256'(model_ready()));
    chk("model_occ",   256'(occ),      256'(model_occ()));
    chk("model_err",   256'(err),      256'(m_err));
    chk("model_rel",   rel_en,         model_rel());
  endtask

  task automatic idle();
    cycle(1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rel",   rel_en,          '0);
    chk("rst_occ",   256'(occ),       '0);
    chk("rst_err",   256'(err),       '0);
    chk("rst_ready", 256'(in_ready),  256'(1));
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       v;
    logic [7:0] id;
    logic [7:0] d;
    logic       rv;
    logic [7:0] rid;
    logic [7:0] chk_id;
    logic       exp_bit;
    logic [3:0] exp_occ;
    logic       exp_rdy;
    logic       exp_err;
  } vec_t;

  vec_t tbl [15];

  initial begin
    tbl[0]  = '{1'b1, 8'd5, 8'd3, 1'b0, 8'd0, 8'd5, 1'b0, 4'd1, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd5, 1'b0, 4'd1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd5, 1'b0, 4'd1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd5, 1'b0, 4'd1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd5, 1'b1, 4'd1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 8'd0, 8'd0, 1'b1, 8'd5, 8'd5, 1'b0, 4'd0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 8'd2, 8'd0, 1'b0, 8'd0, 8'd2, 1'b0, 4'd1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd2, 1'b1, 4'd1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 8'd0, 8'd0, 1'b1, 8'd2, 8'd2, 1'b0, 4'd0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 8'd0, 8'd0, 1'b1, 8'd9, 8'd9, 1'b0, 4'd0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd9, 1'b0, 4'd0, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 8'd3, 8'd1, 1'b0, 8'd0, 8'd3, 1'b0, 4'd1, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd3, 1'b0, 4'd1, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd3, 1'b1, 4'd1, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 8'd0, 8'd0, 1'b1, 8'd3, 8'd3, 1'b0, 4'd0, 1'b1, 1'b1};

    in_valid = 1'b0; in_id = '0; in_delay = '0; rvalid = 1'b0; rid = '0;
    rst_n = 1'b0;
    model_reset();
    #12;
    chk("reset_rel",   rel_en,         '0);
    chk("reset_ready", 256'(in_ready), 256'(1));
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      idle();
      chk("hold_rel",   rel_en,         '0);
      chk("hold_occ",   256'(occ),      '0);
      chk("hold_err",   256'(err),      '0);
      chk("hold_ready", 256'(in_ready), 256'(1));
    end

    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].id, tbl[i].d, tbl[i].rv, tbl[i].rid);
      chk($sformatf("tbl%0d_bit", i),   256'(rel_en[tbl[i].chk_id]), 256'(tbl[i].exp_bit));
      chk($sformatf("tbl%0d_occ", i),   256'(occ),                   256'(tbl[i].exp_occ));
      chk($sformatf("tbl%0d_ready", i), 256'(in_ready),              256'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_err", i),   256'(err),                   256'(tbl[i].exp_err));
    end

    async_reset();

    // Fill every slot, then release slot 0 while a new entry waits.
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(10 + i), 8'd0, 1'b0, 8'd0);
    chk("full_ready", 256'(in_ready), 256'(0));
    chk("full_occ",   256'(occ),      256'(8));
    cycle(1'b1, 8'd20, 8'd0, 1'b1, 8'd10);
    chk("simul_occ",   256'(occ),      256'(7));
    chk("simul_ready", 256'(in_ready), 256'(1));
    chk("simul_bit10", 256'(rel_en[10]), 256'(0));
    cycle(1'b1, 8'd20, 8'd0, 1'b0, 8'd0);
    chk("refill_occ",   256'(occ),      256'(8));
    chk("refill_ready", 256'(in_ready), 256'(0));
    idle();
    chk("refill_bit20", 256'(rel_en[20]), 256'(1));
    for (int i = 11; i < 18; i++) cycle(1'b0, 8'd0, 8'd0, 1'b1, 8'(i));
    cycle(1'b0, 8'd0, 8'd0, 1'b1, 8'd20);
    chk("drain_occ", 256'(occ), 256'(0));

    // Duplicate ID with different delays.
    cycle(1'b1, 8'd7, 8'd1, 1'b0, 8'd0);
    cycle(1'b1, 8'd7, 8'd10, 1'b0, 8'd0);
    chk("dup_bit_a", 256'(rel_en[7]), 256'(0));
    idle();
    chk("dup_bit_b", 256'(rel_en[7]), 256'(1));
    cycle(1'b0, 8'd0, 8'd0, 1'b1, 8'd7);
    chk("dup_bit_c", 256'(rel_en[7]), 256'(0));
    chk("dup_occ_c", 256'(occ),       256'(1));
    for (int i = 0; i < 8; i++) begin
      idle();
      chk("dup_wait", 256'(rel_en[7]), 256'(0));
    end
    idle();
    chk("dup_bit_d", 256'(rel_en[7]), 256'(1));
    cycle(1'b0, 8'd0, 8'd0, 1'b1, 8'd7);
    chk("dup_occ_e", 256'(occ), 256'(0));
    chk("dup_err_e", 256'(err), 256'(0));

    // Reset while entries are in flight.
    cycle(1'b1, 8'd4, 8'd0, 1'b0, 8'd0);
    cycle(1'b1, 8'd6, 8'd5, 1'b0, 8'd0);
    idle();
    async_reset();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int cands[$];
      logic       v, rv;
      logic [7:0] id, d, r;
      for (int s = 0; s < NSlots; s++) if (model_expired(s)) cands.push_back(m_id[s]);
      v  = ($urandom_range(0, 2) != 0);
      id = 8'($urandom_range(0, 7));
      d  = ($urandom_range(0, 63) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
      rv = ($urandom_range(0, 2) != 0);
      if (cands.size() > 0 && $urandom_range(0, 9) != 0)
        r = 8'(cands[$urandom_range(0, cands.size() - 1)]);
      else
        r = 8'($urandom_range(0, 7));
      cycle(v, id, d, rv, r);
      if (n == 1500) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
